// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and occupancy controller for a circular multi-word buffer.
// Turns a valid/ready write port and a valid/ready read port into the buffer
// write enable and the write/read addresses. Data never passes through here.
module fifo_ctrl #(
    parameter int DEPTH     = 5,
    parameter int ADDR_REG  = 2,
    parameter int PAR_WRITE = 1,
    parameter int PAR_READ  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic                rd_ready,
    output logic                rd_valid,
    output logic                wen,
    output logic [ADDR_REG:0]   waddr,
    output logic [ADDR_REG:0]   raddr,
    output logic [ADDR_REG+1:0] count,
    output logic                full,
    output logic                empty
);

    localparam int AW = ADDR_REG + 1;
    localparam int CW = ADDR_REG + 2;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] PW_C    = CW'(PAR_WRITE);
    localparam logic [CW-1:0] PR_C    = CW'(PAR_READ);
    // Highest occupancy that still leaves room for a whole write transfer.
    localparam logic [CW-1:0] ROOM_C  = CW'(DEPTH - PAR_WRITE);

    logic [AW-1:0] wptr_reg, wptr_next;
    logic [AW-1:0] rptr_reg, rptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] wsum, rsum;
    logic          wr_fire, rd_fire;

    // Handshake decode; wr_ready looks only at current occupancy (no bypass).
    always_comb begin
        wr_ready = (count_reg <= ROOM_C);
        rd_valid = (count_reg >= PR_C);
        wr_fire  = wr_valid & wr_ready;
        rd_fire  = rd_ready & rd_valid;
        // A write is never reported to the buffer while flushing or in reset.
        wen      = wr_fire & ~flush & rst;
    end

    // Next pointers and occupancy; sums are one bit wider so the wrap is exact.
    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        count_next = count_reg;
        wsum       = {1'b0, wptr_reg} + PW_C;
        rsum       = {1'b0, rptr_reg} + PR_C;
        if (flush) begin
            wptr_next  = '0;
            rptr_next  = '0;
            count_next = '0;
        end else begin
            // A single conditional subtract suffices since each step is at most DEPTH.
            if (wr_fire) begin
                wptr_next = (wsum >= DEPTH_C) ? AW'(wsum - DEPTH_C) : AW'(wsum);
            end
            if (rd_fire) begin
                rptr_next = (rsum >= DEPTH_C) ? AW'(rsum - DEPTH_C) : AW'(rsum);
            end
            count_next = count_reg + (wr_fire ? PW_C : '0) - (rd_fire ? PR_C : '0);
        end
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            count_reg <= count_next;
        end
    end

    assign waddr = wptr_reg;
    assign raddr = rptr_reg;
    assign count = count_reg;
    assign full  = (count_reg == DEPTH_C);
    assign empty = (count_reg == '0);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed vector table, hand-written
// reset / parameter-sweep sequences, and random traffic against a model.
module tb_fifo_ctrl;

    localparam int DEPTH = 5;
    localparam int AREG  = 2;
    localparam int PW    = 1;
    localparam int PR    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic wr_valid = 1'b0;
    logic rd_ready = 1'b0;
    logic wr_ready, rd_valid, wen, full, empty;
    logic [AREG:0]   waddr, raddr;
    logic [AREG+1:0] count;

    logic b_flush = 1'b0;
    logic b_wv = 1'b0;
    logic b_rr = 1'b0;
    logic b_wr_ready, b_rd_valid, b_wen, b_full, b_empty;
    logic [AREG:0]   b_waddr, b_raddr;
    logic [AREG+1:0] b_count;

    fifo_ctrl #(.DEPTH(DEPTH), .ADDR_REG(AREG), .PAR_WRITE(PW), .PAR_READ(PR)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_ready(rd_ready), .rd_valid(rd_valid),
        .wen(wen), .waddr(waddr), .raddr(raddr),
        .count(count), .full(full), .empty(empty)
    );

    fifo_ctrl #(.DEPTH(5), .ADDR_REG(2), .PAR_WRITE(3), .PAR_READ(1)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .wr_valid(b_wv), .wr_ready(b_wr_ready),
        .rd_ready(b_rr), .rd_valid(b_rd_valid),
        .wen(b_wen), .waddr(b_waddr), .raddr(b_raddr),
        .count(b_count), .full(b_full), .empty(b_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: occupancy and ring positions as plain integers.
    int m_w = 0;
    int m_r = 0;
    int m_cnt = 0;

    int e_wen, e_wrdy, e_rdv, e_full, e_empty, e_waddr, e_raddr, e_count;
    int s_wen, s_wrdy, s_rdv, s_full, s_empty, s_waddr, s_raddr, s_count;

    typedef struct {
        int wv, rr, fl;
        int wen, wrdy, rdv, full, empty, waddr, raddr, count;
    } vec_t;

    vec_t tbl[28];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One cycle on the main instance: drive, sample before the edge, advance model.
    task automatic drive_a(input int wv, input int rr, input int fl, input bit cm);
        bit wf, rf;
        wr_valid = (wv != 0);
        rd_ready = (rr != 0);
        flush    = (fl != 0);
        e_wrdy   = int'((DEPTH - m_cnt) >= PW);
        e_rdv    = int'(m_cnt >= PR);
        e_wen    = int'(wv != 0 && e_wrdy == 1 && fl == 0);
        e_full   = int'(m_cnt == DEPTH);
        e_empty  = int'(m_cnt == 0);
        e_waddr  = m_w;
        e_raddr  = m_r;
        e_count  = m_cnt;
        #1;
        s_wen = int'(wen);     s_wrdy  = int'(wr_ready); s_rdv   = int'(rd_valid);
        s_full = int'(full);   s_empty = int'(empty);    s_waddr = int'(waddr);
        s_raddr = int'(raddr); s_count = int'(count);
        $display("A wv=%0d rr=%0d fl=%0d | wen=%0d wr_ready=%0d rd_valid=%0d waddr=%0d raddr=%0d count=%0d",
                 wv, rr, fl, s_wen, s_wrdy, s_rdv, s_waddr, s_raddr, s_count);
        if (cm) begin
            chk("model.wen", s_wen, e_wen);
            chk("model.wr_ready", s_wrdy, e_wrdy);
            chk("model.rd_valid", s_rdv, e_rdv);
            chk("model.full", s_full, e_full);
            chk("model.empty", s_empty, e_empty);
            chk("model.waddr", s_waddr, e_waddr);
            chk("model.raddr", s_raddr, e_raddr);
            chk("model.count", s_count, e_count);
        end
        @(posedge clk);
        if (fl != 0) begin
            m_w = 0; m_r = 0; m_cnt = 0;
        end else begin
            wf = (wv != 0) && (e_wrdy == 1);
            rf = (rr != 0) && (e_rdv == 1);
            if (wf) m_w = (m_w + PW) % DEPTH;
            if (rf) m_r = (m_r + PR) % DEPTH;
            m_cnt = m_cnt + (wf ? PW : 0) - (rf ? PR : 0);
        end
        @(negedge clk);
    endtask

    // One cycle on the PAR_WRITE=3 / PAR_READ=1 instance with explicit expectations.
    task automatic b_step(input int wv, input int rr, input int ewrdy, input int ewen,
                          input int erdv, input int ewaddr, input int eraddr, input int ecount);
        b_wv = (wv != 0);
        b_rr = (rr != 0);
        #1;
        $display("B wv=%0d rr=%0d | wen=%0d wr_ready=%0d waddr=%0d raddr=%0d count=%0d",
                 wv, rr, b_wen, b_wr_ready, b_waddr, b_raddr, b_count);
        chk("B.wr_ready", int'(b_wr_ready), ewrdy);
        chk("B.wen", int'(b_wen), ewen);
        chk("B.rd_valid", int'(b_rd_valid), erdv);
        chk("B.waddr", int'(b_waddr), ewaddr);
        chk("B.raddr", int'(b_raddr), eraddr);
        chk("B.count", int'(b_count), ecount);
        chk("B.full", int'(b_full), int'(ecount == 5));
        chk("B.empty", int'(b_empty), int'(ecount == 0));
        @(posedge clk);
        @(negedge clk);
        b_wv = 1'b0;
        b_rr = 1'b0;
    endtask

    initial begin
        //         wv rr fl  wen wrdy rdv full empty waddr raddr count
        tbl[0]  = '{1, 0, 0,  1, 1, 0, 0, 1, 0, 0, 0};
        tbl[1]  = '{1, 0, 0,  1, 1, 0, 0, 0, 1, 0, 1};
        tbl[2]  = '{1, 0, 0,  1, 1, 1, 0, 0, 2, 0, 2};
        tbl[3]  = '{1, 0, 0,  1, 1, 1, 0, 0, 3, 0, 3};
        tbl[4]  = '{1, 0, 0,  1, 1, 1, 0, 0, 4, 0, 4};
        tbl[5]  = '{1, 0, 0,  0, 0, 1, 1, 0, 0, 0, 5};
        tbl[6]  = '{0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 5};
        tbl[7]  = '{1, 0, 0,  1, 1, 1, 0, 0, 0, 2, 3};
        tbl[8]  = '{1, 1, 1,  0, 1, 1, 0, 0, 1, 2, 4};
        tbl[9]  = '{1, 0, 0,  1, 1, 0, 0, 1, 0, 0, 0};
        tbl[10] = '{1, 0, 0,  1, 1, 0, 0, 0, 1, 0, 1};
        tbl[11] = '{0, 1, 0,  0, 1, 1, 0, 0, 2, 0, 2};
        tbl[12] = '{1, 0, 0,  1, 1, 0, 0, 1, 2, 2, 0};
        tbl[13] = '{1, 0, 0,  1, 1, 0, 0, 0, 3, 2, 1};
        tbl[14] = '{1, 0, 0,  1, 1, 1, 0, 0, 4, 2, 2};
        tbl[15] = '{1, 0, 0,  1, 1, 1, 0, 0, 0, 2, 3};
        tbl[16] = '{0, 1, 0,  0, 1, 1, 0, 0, 1, 2, 4};
        tbl[17] = '{0, 1, 0,  0, 1, 1, 0, 0, 1, 4, 2};
        tbl[18] = '{0, 0, 1,  0, 1, 0, 0, 1, 1, 1, 0};
        tbl[19] = '{1, 0, 0,  1, 1, 0, 0, 1, 0, 0, 0};
        tbl[20] = '{1, 0, 0,  1, 1, 0, 0, 0, 1, 0, 1};
        tbl[21] = '{1, 0, 0,  1, 1, 1, 0, 0, 2, 0, 2};
        tbl[22] = '{1, 1, 0,  1, 1, 1, 0, 0, 3, 0, 3};
        tbl[23] = '{1, 0, 0,  1, 1, 1, 0, 0, 4, 2, 2};
        tbl[24] = '{1, 0, 0,  1, 1, 1, 0, 0, 0, 2, 3};
        tbl[25] = '{1, 0, 0,  1, 1, 1, 0, 0, 1, 2, 4};
        tbl[26] = '{1, 1, 0,  0, 0, 1, 1, 0, 2, 2, 5};
        tbl[27] = '{0, 0, 0,  0, 1, 1, 0, 0, 2, 4, 3};

        // Held in reset with a write offered: nothing may be accepted.
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            $display("RST cycle %0d: wen=%0d count=%0d empty=%0d wr_ready=%0d", i, wen, count, empty, wr_ready);
            chk("rst.wen", int'(wen), 0);
            chk("rst.count", int'(count), 0);
            chk("rst.empty", int'(empty), 1);
            chk("rst.full", int'(full), 0);
            chk("rst.wr_ready", int'(wr_ready), 1);
            chk("rst.rd_valid", int'(rd_valid), 0);
            chk("rst.waddr", int'(waddr), 0);
            chk("rst.raddr", int'(raddr), 0);
        end
        @(negedge clk);
        rst = 1'b1;
        wr_valid = 1'b0;

        // PAR_WRITE=3, PAR_READ=1: wr_ready drops at count >= 3, waddr 0,3,1.
        b_step(1, 0, 1, 1, 0, 0, 0, 0);
        b_step(1, 0, 0, 0, 1, 3, 0, 3);
        b_step(1, 1, 0, 0, 1, 3, 0, 3);
        b_step(1, 0, 1, 1, 1, 3, 1, 2);
        b_step(0, 1, 0, 0, 1, 1, 1, 5);
        b_step(1, 0, 0, 0, 1, 1, 2, 4);

        // Directed vectors: fill, threshold, wrap, flush, simultaneous fires.
        for (int i = 0; i < 28; i++) begin
            drive_a(tbl[i].wv, tbl[i].rr, tbl[i].fl, 1'b0);
            chk($sformatf("vec%0d.wen", i), s_wen, tbl[i].wen);
            chk($sformatf("vec%0d.wr_ready", i), s_wrdy, tbl[i].wrdy);
            chk($sformatf("vec%0d.rd_valid", i), s_rdv, tbl[i].rdv);
            chk($sformatf("vec%0d.full", i), s_full, tbl[i].full);
            chk($sformatf("vec%0d.empty", i), s_empty, tbl[i].empty);
            chk($sformatf("vec%0d.waddr", i), s_waddr, tbl[i].waddr);
            chk($sformatf("vec%0d.raddr", i), s_raddr, tbl[i].raddr);
            chk($sformatf("vec%0d.count", i), s_count, tbl[i].count);
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            drive_a(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15) == 0), 1'b1);
        end

        // Asynchronous reset asserted between edges while a write is firing.
        drive_a(0, 0, 1, 1'b1);
        drive_a(1, 0, 0, 1'b1);
        drive_a(1, 0, 0, 1'b1);
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        $display("ASYNC RST: wen=%0d count=%0d waddr=%0d raddr=%0d", wen, count, waddr, raddr);
        chk("arst.count", int'(count), 0);
        chk("arst.waddr", int'(waddr), 0);
        chk("arst.raddr", int'(raddr), 0);
        chk("arst.empty", int'(empty), 1);
        chk("arst.wen", int'(wen), 0);
        chk("arst.rd_valid", int'(rd_valid), 0);
        @(posedge clk);
        #1;
        chk("arst.hold_count", int'(count), 0);
        chk("arst.hold_waddr", int'(waddr), 0);
        @(negedge clk);
        rst = 1'b1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        m_w = 0; m_r = 0; m_cnt = 0;
        drive_a(1, 0, 0, 1'b1);
        drive_a(1, 0, 0, 1'b1);
        drive_a(0, 1, 0, 1'b1);
        drive_a(0, 0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
